// File: rtl/atomrvcore_exec_ctrl_pkg.sv
// Shared types for the execute-stage pipeline controller: FSM states, operand
// source selects and the shadow slot that tracks an in-flight instruction.
package atomrvcore_exec_ctrl_pkg;

   // Widest register index a slot can track; narrower indices are zero-extended.
   localparam int SLOT_RD_W = 8;

   typedef enum logic [1:0] {
      ST_RUN       = 2'b00,
      ST_LOAD_WAIT = 2'b01,
      ST_FLUSH     = 2'b10
   } state_t;

   typedef enum logic [1:0] {
      REGF = 2'b00,
      EXR  = 2'b01,
      MEMR = 2'b10
   } fwd_sel_t;

   typedef struct packed {
      logic                 valid;
      logic [SLOT_RD_W-1:0] rd;
      logic                 rwr;
      logic                 load;
   } slot_t;

endpackage

// File: rtl/atomrvcore_exec_ctrl_hazard_unit.sv
// Per-operand source compare: picks the operand source and flags a stall.
// ATOMRV_FWD_EN enables EX/MEM forwarding; without it every RAW match stalls.
module atomrvcore_exec_ctrl_hazard_unit
   import atomrvcore_exec_ctrl_pkg::*;
(
   input  logic [SLOT_RD_W-1:0] rs,
   input  logic                 rs_use,
   input  logic                 ex_valid,
   input  logic [SLOT_RD_W-1:0] ex_rd,
   input  logic                 ex_rwr,
   input  logic                 ex_load,
   input  logic                 mem_valid,
   input  logic [SLOT_RD_W-1:0] mem_rd,
   input  logic                 mem_rwr,
   output logic [1:0]           fwd_sel,
   output logic                 stall_req
);

   logic ex_hit;
   logic mem_hit;
   logic load_use;

   // x0 is hard-wired zero, so it never matches a producer.
   assign ex_hit   = ex_valid  && (ex_rd  != '0) && (ex_rd  == rs);
   assign mem_hit  = mem_valid && (mem_rd != '0) && (mem_rd == rs);
   assign load_use = rs_use && ex_hit && ex_load;

`ifdef ATOMRV_FWD_EN
   always_comb begin
      fwd_sel = REGF;
      if (ex_hit && ex_rwr && !ex_load) begin
         fwd_sel = EXR;
      end else if (mem_hit && mem_rwr) begin
         fwd_sel = MEMR;
      end
   end

   assign stall_req = load_use;
`else
   assign fwd_sel   = REGF;
   assign stall_req = load_use || (rs_use && ((ex_hit && ex_rwr) || (mem_hit && mem_rwr)));
`endif

endmodule

// File: rtl/atomrvcore_exec_ctrl.sv
// Execute-stage pipeline controller: redirect/flush, load-use stalls, load-wait
// freeze with timeout error, operand forwarding (enabled by ATOMRV_FWD_EN).
module atomrvcore_exec_ctrl
   import atomrvcore_exec_ctrl_pkg::*;
#(
   parameter int DATAWIDTH        = 32,
   parameter int REG_ADRESS_WIDTH = 5,
   parameter int MEM_WAIT_MAX     = 15
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        id_valid_i,
   input  logic [REG_ADRESS_WIDTH-1:0] id_rs1_i,
   input  logic [REG_ADRESS_WIDTH-1:0] id_rs2_i,
   input  logic                        id_rs1_use_i,
   input  logic                        id_rs2_use_i,
   input  logic [REG_ADRESS_WIDTH-1:0] id_rd_i,
   input  logic                        id_rwr_en_i,
   input  logic                        id_dr_en_i,
   input  logic                        ex_be_i,
   input  logic [DATAWIDTH-1:0]        ex_pc_i,
   input  logic                        mem_ack_i,
   output logic                        stall_if_o,
   output logic                        stall_id_o,
   output logic                        flush_id_o,
   output logic                        flush_ex_o,
   output logic                        ex_valid_o,
   output logic                        pc_sel_o,
   output logic [DATAWIDTH-1:0]        pc_target_o,
   output logic [1:0]                  fwd_a_o,
   output logic [1:0]                  fwd_b_o,
   output logic                        err_o,
   output logic [1:0]                  state_o
);

   localparam int             CNT_W   = $clog2(MEM_WAIT_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_WAIT_MAX);

   state_t           state_q, state_d;
   slot_t            ex_q, mem_q, id_slot;
   logic [CNT_W-1:0] cnt_q, cnt_nxt;
   logic             err_q;
   logic             mem_wait, hold, hz_a, hz_b;
   logic             stall_c, flush_id_c, flush_ex_c, issue_c, pc_sel_c;
   logic [1:0]       fwd_a_c, fwd_b_c;

   assign id_slot = '{valid: 1'b1, rd: SLOT_RD_W'(id_rd_i), rwr: id_rwr_en_i, load: id_dr_en_i};

   atomrvcore_exec_ctrl_hazard_unit u_hz_a (
      .rs        (SLOT_RD_W'(id_rs1_i)),
      .rs_use    (id_rs1_use_i),
      .ex_valid  (ex_q.valid),
      .ex_rd     (ex_q.rd),
      .ex_rwr    (ex_q.rwr),
      .ex_load   (ex_q.load),
      .mem_valid (mem_q.valid),
      .mem_rd    (mem_q.rd),
      .mem_rwr   (mem_q.rwr),
      .fwd_sel   (fwd_a_c),
      .stall_req (hz_a)
   );

   atomrvcore_exec_ctrl_hazard_unit u_hz_b (
      .rs        (SLOT_RD_W'(id_rs2_i)),
      .rs_use    (id_rs2_use_i),
      .ex_valid  (ex_q.valid),
      .ex_rd     (ex_q.rd),
      .ex_rwr    (ex_q.rwr),
      .ex_load   (ex_q.load),
      .mem_valid (mem_q.valid),
      .mem_rd    (mem_q.rd),
      .mem_rwr   (mem_q.rwr),
      .fwd_sel   (fwd_b_c),
      .stall_req (hz_b)
   );

   // A load sitting in MEM without its ack must not advance: freeze from this cycle on.
   assign mem_wait = mem_q.valid && mem_q.load && !mem_ack_i;
   assign cnt_nxt  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

   always_comb begin
      state_d    = state_q;
      hold       = 1'b0;
      stall_c    = 1'b0;
      flush_id_c = 1'b0;
      flush_ex_c = 1'b0;
      pc_sel_c   = 1'b0;
      issue_c    = id_valid_i;
      case (state_q)
         ST_RUN: begin
            if (mem_wait) begin
               hold    = 1'b1;
               stall_c = 1'b1;
               issue_c = 1'b0;
               state_d = ST_LOAD_WAIT;
            end else if (ex_be_i) begin
               pc_sel_c   = 1'b1;
               flush_id_c = 1'b1;
               flush_ex_c = 1'b1;
               issue_c    = 1'b0;
               state_d    = ST_FLUSH;
            end else if (id_valid_i && (hz_a || hz_b)) begin
               stall_c = 1'b1;
               issue_c = 1'b0;
            end
         end
         ST_LOAD_WAIT: begin
            hold    = 1'b1;
            stall_c = 1'b1;
            issue_c = 1'b0;
            if (mem_ack_i) state_d = ST_RUN;
         end
         ST_FLUSH: begin
            flush_id_c = 1'b1;
            issue_c    = 1'b0;
            state_d    = ST_RUN;
            if (mem_wait) begin
               hold    = 1'b1;
               stall_c = 1'b1;
               state_d = ST_LOAD_WAIT;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_RUN;
         ex_q    <= '0;
         mem_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         // On ack the load has its data; drop the load flag so the exit cycle does not re-wait.
         if (hold) begin
            if ((state_q == ST_LOAD_WAIT) && mem_ack_i) mem_q.load <= 1'b0;
         end else begin
            ex_q  <= issue_c ? id_slot : '0;
            mem_q <= ex_q;
         end
         if (state_q == ST_LOAD_WAIT) begin
            cnt_q <= cnt_nxt;
            if (cnt_nxt == CNT_MAX) err_q <= 1'b1;
         end else begin
            cnt_q <= '0;
         end
      end
   end

   assign stall_if_o  = !rst_i && stall_c;
   assign stall_id_o  = !rst_i && stall_c;
   assign flush_id_o  = !rst_i && flush_id_c;
   assign flush_ex_o  = !rst_i && flush_ex_c;
   assign ex_valid_o  = !rst_i && issue_c;
   assign pc_sel_o    = !rst_i && pc_sel_c;
   assign pc_target_o = (!rst_i && pc_sel_c) ? ex_pc_i : '0;
   assign fwd_a_o     = rst_i ? 2'b00 : fwd_a_c;
   assign fwd_b_o     = rst_i ? 2'b00 : fwd_b_c;
   assign err_o       = err_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_atomrvcore_exec_ctrl.sv
// Directed bench for atomrvcore_exec_ctrl; expectations follow ATOMRV_FWD_EN.
module tb_atomrvcore_exec_ctrl;

`ifdef ATOMRV_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_i;
   logic        id_valid_i;
   logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
   logic        id_rs1_use_i, id_rs2_use_i, id_rwr_en_i, id_dr_en_i;
   logic        ex_be_i;
   logic [31:0] ex_pc_i;
   logic        mem_ack_i;
   logic        stall_if_o, stall_id_o, flush_id_o, flush_ex_o, ex_valid_o, pc_sel_o, err_o;
   logic [31:0] pc_target_o;
   logic [1:0]  fwd_a_o, fwd_b_o, state_o;

   int checks   = 0;
   int failures = 0;

   atomrvcore_exec_ctrl dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .id_valid_i   (id_valid_i),
      .id_rs1_i     (id_rs1_i),
      .id_rs2_i     (id_rs2_i),
      .id_rs1_use_i (id_rs1_use_i),
      .id_rs2_use_i (id_rs2_use_i),
      .id_rd_i      (id_rd_i),
      .id_rwr_en_i  (id_rwr_en_i),
      .id_dr_en_i   (id_dr_en_i),
      .ex_be_i      (ex_be_i),
      .ex_pc_i      (ex_pc_i),
      .mem_ack_i    (mem_ack_i),
      .stall_if_o   (stall_if_o),
      .stall_id_o   (stall_id_o),
      .flush_id_o   (flush_id_o),
      .flush_ex_o   (flush_ex_o),
      .ex_valid_o   (ex_valid_o),
      .pc_sel_o     (pc_sel_o),
      .pc_target_o  (pc_target_o),
      .fwd_a_o      (fwd_a_o),
      .fwd_b_o      (fwd_b_o),
      .err_o        (err_o),
      .state_o      (state_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_dec(input logic v, input logic [4:0] rd, input logic rwr, input logic ld,
                          input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2);
      id_valid_i   = v;
      id_rd_i      = rd;
      id_rwr_en_i  = rwr;
      id_dr_en_i   = ld;
      id_rs1_i     = rs1;
      id_rs1_use_i = u1;
      id_rs2_i     = rs2;
      id_rs2_use_i = u2;
   endtask

   task automatic drain();
      set_dec(0, 0, 0, 0, 0, 0, 0, 0);
      ex_be_i   = 1'b0;
      mem_ack_i = 1'b1;
      repeat (3) tick();
   endtask

   task automatic test_reset();
      rst_i = 1'b1; ex_be_i = 1'b1; ex_pc_i = 32'h55; mem_ack_i = 1'b0;
      set_dec(1, 5, 1, 0, 5, 1, 5, 1);
      @(negedge clk);
      checks++; if (stall_if_o !== 1'b0) begin failures++; $display("FAIL rst_stall_if got=%0b exp=0", stall_if_o); end
      checks++; if (flush_id_o !== 1'b0) begin failures++; $display("FAIL rst_flush_id got=%0b exp=0", flush_id_o); end
      checks++; if (pc_sel_o !== 1'b0) begin failures++; $display("FAIL rst_pc_sel got=%0b exp=0", pc_sel_o); end
      checks++; if (ex_valid_o !== 1'b0) begin failures++; $display("FAIL rst_ex_valid got=%0b exp=0", ex_valid_o); end
      checks++; if (pc_target_o !== 32'h0) begin failures++; $display("FAIL rst_pc_target got=%0h exp=0", pc_target_o); end
      checks++; if (fwd_a_o !== 2'b00) begin failures++; $display("FAIL rst_fwd_a got=%0b exp=00", fwd_a_o); end
      tick();
      rst_i = 1'b0; ex_be_i = 1'b0; mem_ack_i = 1'b1;
      set_dec(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checks++; if (state_o !== 2'b00) begin failures++; $display("FAIL rst_state got=%0b exp=00", state_o); end
      checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL rst_err got=%0b exp=0", err_o); end
      checks++; if (stall_id_o !== 1'b0) begin failures++; $display("FAIL rst_stall_id got=%0b exp=0", stall_id_o); end
      tick();
   endtask

   // Two ADD x5 back to back, then a reader of x5 held in decode for three cycles.
   task automatic test_fwd_ex();
      drain();
      set_dec(1, 5, 1, 0, 0, 0, 0, 0);
      @(negedge clk);
      checks++; if (ex_valid_o !== 1'b1) begin failures++; $display("FAIL fwd_issue got=%0b exp=1", ex_valid_o); end
      tick();
      tick();
      set_dec(1, 7, 1, 0, 5, 1, 0, 0);
      @(negedge clk);
      checks++; if (fwd_a_o !== (FWD ? 2'b01 : 2'b00)) begin failures++; $display("FAIL fwd_ex_a got=%0b exp=%0b", fwd_a_o, FWD ? 2'b01 : 2'b00); end
      checks++; if (stall_id_o !== !FWD) begin failures++; $display("FAIL fwd_ex_stall got=%0b exp=%0b", stall_id_o, !FWD); end
      checks++; if (ex_valid_o !== FWD) begin failures++; $display("FAIL fwd_ex_valid got=%0b exp=%0b", ex_valid_o, FWD); end
      tick();
      @(negedge clk);
      checks++; if (fwd_a_o !== (FWD ? 2'b10 : 2'b00)) begin failures++; $display("FAIL fwd_mem_a got=%0b exp=%0b", fwd_a_o, FWD ? 2'b10 : 2'b00); end
      checks++; if (stall_id_o !== !FWD) begin failures++; $display("FAIL fwd_mem_stall got=%0b exp=%0b", stall_id_o, !FWD); end
      tick();
      @(negedge clk);
      checks++; if (fwd_a_o !== 2'b00) begin failures++; $display("FAIL fwd_clear_a got=%0b exp=00", fwd_a_o); end
      checks++; if (stall_id_o !== 1'b0) begin failures++; $display("FAIL fwd_clear_stall got=%0b exp=0", stall_id_o); end
      checks++; if (ex_valid_o !== 1'b1) begin failures++; $display("FAIL fwd_clear_valid got=%0b exp=1", ex_valid_o); end
      tick();
   endtask

   task automatic test_load_use();
      drain();
      set_dec(1, 6, 1, 1, 0, 0, 0, 0);
      tick();
      set_dec(1, 8, 1, 0, 0, 0, 6, 1);
      @(negedge clk);
      checks++; if (stall_if_o !== 1'b1) begin failures++; $display("FAIL lu_stall_if got=%0b exp=1", stall_if_o); end
      checks++; if (stall_id_o !== 1'b1) begin failures++; $display("FAIL lu_stall_id got=%0b exp=1", stall_id_o); end
      checks++; if (ex_valid_o !== 1'b0) begin failures++; $display("FAIL lu_bubble got=%0b exp=0", ex_valid_o); end
      checks++; if (fwd_b_o !== 2'b00) begin failures++; $display("FAIL lu_fwd_b got=%0b exp=00", fwd_b_o); end
      tick();
      @(negedge clk);
      checks++; if (fwd_b_o !== (FWD ? 2'b10 : 2'b00)) begin failures++; $display("FAIL lu_next_fwd_b got=%0b exp=%0b", fwd_b_o, FWD ? 2'b10 : 2'b00); end
      checks++; if (stall_id_o !== !FWD) begin failures++; $display("FAIL lu_next_stall got=%0b exp=%0b", stall_id_o, !FWD); end
      checks++; if (ex_valid_o !== FWD) begin failures++; $display("FAIL lu_next_valid got=%0b exp=%0b", ex_valid_o, FWD); end
      tick();
      @(negedge clk);
      checks++; if (stall_id_o !== 1'b0) begin failures++; $display("FAIL lu_done_stall got=%0b exp=0", stall_id_o); end
      tick();
   endtask

   task automatic test_redirect();
      drain();
      set_dec(1, 3, 1, 0, 0, 0, 0, 0);
      ex_be_i = 1'b1; ex_pc_i = 32'h0000_0100;
      @(negedge clk);
      checks++; if (state_o !== 2'b00) begin failures++; $display("FAIL br_state0 got=%0b exp=00", state_o); end
      checks++; if (pc_sel_o !== 1'b1) begin failures++; $display("FAIL br_pc_sel got=%0b exp=1", pc_sel_o); end
      checks++; if (pc_target_o !== 32'h100) begin failures++; $display("FAIL br_target got=%0h exp=100", pc_target_o); end
      checks++; if (flush_id_o !== 1'b1) begin failures++; $display("FAIL br_flush_id0 got=%0b exp=1", flush_id_o); end
      checks++; if (flush_ex_o !== 1'b1) begin failures++; $display("FAIL br_flush_ex got=%0b exp=1", flush_ex_o); end
      checks++; if (ex_valid_o !== 1'b0) begin failures++; $display("FAIL br_valid0 got=%0b exp=0", ex_valid_o); end
      tick();
      ex_be_i = 1'b0;
      @(negedge clk);
      checks++; if (state_o !== 2'b10) begin failures++; $display("FAIL br_state1 got=%0b exp=10", state_o); end
      checks++; if (flush_id_o !== 1'b1) begin failures++; $display("FAIL br_flush_id1 got=%0b exp=1", flush_id_o); end
      checks++; if (flush_ex_o !== 1'b0) begin failures++; $display("FAIL br_flush_ex1 got=%0b exp=0", flush_ex_o); end
      checks++; if (pc_sel_o !== 1'b0) begin failures++; $display("FAIL br_pc_sel1 got=%0b exp=0", pc_sel_o); end
      checks++; if (ex_valid_o !== 1'b0) begin failures++; $display("FAIL br_valid1 got=%0b exp=0", ex_valid_o); end
      tick();
      @(negedge clk);
      checks++; if (state_o !== 2'b00) begin failures++; $display("FAIL br_state2 got=%0b exp=00", state_o); end
      checks++; if (flush_id_o !== 1'b0) begin failures++; $display("FAIL br_flush_id2 got=%0b exp=0", flush_id_o); end
      checks++; if (ex_valid_o !== 1'b1) begin failures++; $display("FAIL br_valid2 got=%0b exp=1", ex_valid_o); end
      tick();
   endtask

   // Issue a load, let it reach MEM with an idle cycle behind it.
   task automatic load_to_mem();
      drain();
      set_dec(1, 9, 1, 1, 0, 0, 0, 0);
      tick();
      set_dec(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_load_wait();
      logic [1:0] exp_st;
      load_to_mem();
      set_dec(1, 4, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) begin
         mem_ack_i = (k >= 3);
         if (k == 4) mem_ack_i = 1'b0;
         exp_st = (k >= 1 && k <= 3) ? 2'b01 : 2'b00;
         @(negedge clk);
         checks++; if (state_o !== exp_st) begin failures++; $display("FAIL lw_state k=%0d got=%0b exp=%0b", k, state_o, exp_st); end
         checks++; if (stall_if_o !== (k <= 3)) begin failures++; $display("FAIL lw_stall k=%0d got=%0b exp=%0b", k, stall_if_o, k <= 3); end
         checks++; if (ex_valid_o !== (k == 4)) begin failures++; $display("FAIL lw_valid k=%0d got=%0b exp=%0b", k, ex_valid_o, k == 4); end
         tick();
      end
      @(negedge clk);
      checks++; if (state_o !== 2'b00) begin failures++; $display("FAIL lw_resume_state got=%0b exp=00", state_o); end
      checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL lw_err got=%0b exp=0", err_o); end
      tick();
   endtask

   task automatic test_timeout();
      logic       exp_err;
      logic [1:0] exp_st;
      load_to_mem();
      mem_ack_i = 1'b0;
      for (int k = 0; k < 20; k++) begin
         exp_err = (k >= 16);
         exp_st  = (k == 0) ? 2'b00 : 2'b01;
         @(negedge clk);
         checks++; if (err_o !== exp_err) begin failures++; $display("FAIL to_err k=%0d got=%0b exp=%0b", k, err_o, exp_err); end
         checks++; if (state_o !== exp_st) begin failures++; $display("FAIL to_state k=%0d got=%0b exp=%0b", k, state_o, exp_st); end
         tick();
      end
      rst_i = 1'b1;
      @(negedge clk);
      checks++; if (stall_if_o !== 1'b0) begin failures++; $display("FAIL to_rst_stall got=%0b exp=0", stall_if_o); end
      tick();
      rst_i = 1'b0;
      @(negedge clk);
      checks++; if (state_o !== 2'b00) begin failures++; $display("FAIL to_rst_state got=%0b exp=00", state_o); end
      checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL to_rst_err got=%0b exp=0", err_o); end
      checks++; if (stall_id_o !== 1'b0) begin failures++; $display("FAIL to_rst_free got=%0b exp=0", stall_id_o); end
      tick();
   endtask

   // ADD x0 then LW x0, followed by a reader of x0 on both operands.
   task automatic test_x0();
      drain();
      set_dec(1, 0, 1, 0, 0, 0, 0, 0);
      tick();
      set_dec(1, 0, 1, 1, 0, 0, 0, 0);
      tick();
      set_dec(1, 0, 0, 0, 0, 1, 0, 1);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checks++; if (fwd_a_o !== 2'b00) begin failures++; $display("FAIL x0_fwd_a k=%0d got=%0b exp=00", k, fwd_a_o); end
         checks++; if (fwd_b_o !== 2'b00) begin failures++; $display("FAIL x0_fwd_b k=%0d got=%0b exp=00", k, fwd_b_o); end
         checks++; if (stall_id_o !== 1'b0) begin failures++; $display("FAIL x0_stall k=%0d got=%0b exp=0", k, stall_id_o); end
         checks++; if (ex_valid_o !== 1'b1) begin failures++; $display("FAIL x0_valid k=%0d got=%0b exp=1", k, ex_valid_o); end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_fwd_ex();
      test_load_use();
      test_redirect();
      test_load_wait();
      test_timeout();
      test_x0();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
